// File: rtl/reg_dump_pkg.sv
// Shared types and defaults for the register-file dump engine.
package reg_dump_pkg;

    localparam int unsigned NREGS_DEF = 16;
    localparam int unsigned WIDTH_DEF = 32;
    localparam int unsigned SEQ_W     = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/reg_dump_shadow.sv
// Shadow copy of the last emitted value of every register, used by the
// changed-only dump mode. match_c_o is a combinational compare of the
// shadow entry at rd_idx_i against the live read data.
module reg_dump_shadow
    import reg_dump_pkg::*;
#(
    parameter int unsigned NREGS = NREGS_DEF,
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned IDX_W = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx_i,
    input  logic [WIDTH-1:0] cmp_data_i,
    output logic             match_c_o,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [WIDTH-1:0] wr_data_i
);

    logic [WIDTH-1:0] mem_q [NREGS];

    // Shadow store: cleared on reset, written when a beat is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign match_c_o = (mem_q[rd_idx_i] == cmp_data_i);

endmodule

// File: rtl/reg_dump_unit.sv
// Register-file dump engine: walks indices 0..NREGS-1 through the read port
// and streams {index, value} beats over valid/ready, followed by a one-cycle
// done pulse and a sequence-number bump.
// Optional feature: define REG_DUMP_CHANGED_ONLY_EN to emit only registers
// whose value differs from the one emitted by the previous dump.
module reg_dump_unit
    import reg_dump_pkg::*;
#(
    parameter int unsigned NREGS = NREGS_DEF,
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned IDX_W = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] rf_raddr,
    input  logic [WIDTH-1:0] rf_rdata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_index,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic [SEQ_W-1:0] out_seq
);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             out_valid_q, out_valid_d;
    logic [IDX_W-1:0] out_index_q, out_index_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_last_q, out_last_d;
    logic [SEQ_W-1:0] seq_q, seq_d;

    logic             hs_c;
    logic             last_idx_c;
    logic             emit_c;

    assign hs_c       = out_valid_q & out_ready;
    assign last_idx_c = (idx_q == IDX_W'(NREGS - 1));

`ifdef REG_DUMP_CHANGED_ONLY_EN
    logic match_c;

    // Registers equal to their last emitted value are skipped.
    reg_dump_shadow #(
        .NREGS (NREGS),
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_shadow (
        .clk        (clk),
        .rst_n      (rst),
        .rd_idx_i   (idx_q),
        .cmp_data_i (rf_rdata),
        .match_c_o  (match_c),
        .wr_en_i    (hs_c),
        .wr_idx_i   (out_index_q),
        .wr_data_i  (out_data_q)
    );

    assign emit_c = ~match_c;
`else
    assign emit_c = 1'b1;
`endif

    // Next-state and output-register logic for the dump walk.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        out_index_d = out_index_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        seq_d       = seq_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    idx_d   = '0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (emit_c) begin
                    out_data_d  = rf_rdata;
                    out_index_d = idx_q;
                    out_valid_d = 1'b1;
                    out_last_d  = last_idx_c;
                    state_d     = ST_SEND;
                end else if (last_idx_c) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = ST_LOAD;
                end
            end
            ST_SEND: begin
                if (hs_c) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (last_idx_c) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_DONE: begin
                seq_d   = seq_q + SEQ_W'(1);
                idx_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                idx_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers; reset abandons any dump in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_index_q <= '0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            seq_q       <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            out_valid_q <= out_valid_d;
            out_index_q <= out_index_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            seq_q       <= seq_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign rf_raddr  = idx_q;
    assign out_valid = out_valid_q;
    assign out_index = out_index_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_seq   = seq_q;

endmodule

// File: tb/tb_reg_dump_unit.sv
// Self-checking bench for reg_dump_unit: a queue-based model of the beats
// each dump must produce, checked every cycle, plus directed literal checks.
`timescale 1ns/1ps
module tb_reg_dump_unit;
    import reg_dump_pkg::*;

    localparam int unsigned NREGS = 16;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned IDX_W = $clog2(NREGS);
    localparam int          LIMIT = 3000;
`ifdef REG_DUMP_CHANGED_ONLY_EN
    localparam bit CHG = 1'b1;
`else
    localparam bit CHG = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             busy;
    logic             done;
    logic [IDX_W-1:0] rf_raddr;
    logic [WIDTH-1:0] rf_rdata;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_index;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic [SEQ_W-1:0] out_seq;

    logic [WIDTH-1:0] regs [NREGS];
    assign rf_rdata = regs[rf_raddr];

    always #5 clk = ~clk;

    reg_dump_unit #(.NREGS(NREGS), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .rf_raddr  (rf_raddr),
        .rf_rdata  (rf_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_seq   (out_seq)
    );

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [WIDTH-1:0] data;
        logic             last;
    } beat_t;

    beat_t            exp_q[$];
    logic [WIDTH-1:0] shadow_m [NREGS];
    logic [7:0]       exp_seq = 8'd0;
    logic             busy_prev = 1'b0;
    int n_vec = 0, n_err = 0;
    int starts = 0, finishes = 0;
    int cyc = 0, beats = 0, stalls = 0, gap = 0;
    int ready_mode = 0, stall_left = 3;
    int last_cycles = 0, last_beats = 0, last_stalls = 0, last_first_idx = -1, last_gap = 0;
    int first_idx = -1;
    logic [7:0] last_seq = 8'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected beats of one dump, from the register contents at its start.
    task automatic build_expected();
        beat_t b;
        exp_q.delete();
        for (int i = 0; i < int'(NREGS); i++) begin
            if (!CHG || regs[i] != shadow_m[i]) begin
                b.idx  = IDX_W'(i);
                b.data = regs[i];
                b.last = (i == int'(NREGS) - 1);
                exp_q.push_back(b);
                shadow_m[i] = regs[i];
            end
        end
    endtask

    task automatic compare_cycle();
        if (!rst) begin
            exp_q.delete();
            for (int i = 0; i < int'(NREGS); i++) shadow_m[i] = '0;
            exp_seq   = 8'd0;
            busy_prev = 1'b0;
            finishes  = starts;
            gap       = 0;
        end else begin
            if (busy && !busy_prev) begin
                build_expected();
                cyc = 0; beats = 0; stalls = 0; first_idx = -1;
                last_gap = gap;
            end
            busy_prev = busy;
            if (busy) begin
                cyc++;
                chk("busy_has_request", 64'(starts > finishes), 64'd1);
            end else begin
                gap++;
                chk("idle_raddr", 64'(rf_raddr), 64'd0);
                chk("idle_valid", 64'(out_valid), 64'd0);
                chk("idle_done", 64'(done), 64'd0);
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_beat: index %0d data 0x%0h, no beat expected", out_index, out_data);
                end else begin
                    chk("out_index", 64'(out_index), 64'(exp_q[0].idx));
                    chk("out_data", 64'(out_data), 64'(exp_q[0].data));
                    chk("out_last", 64'(out_last), 64'(exp_q[0].last));
                    chk("out_seq", 64'(out_seq), 64'(exp_seq));
                    if (out_ready) begin
                        if (beats == 0) first_idx = int'(out_index);
                        void'(exp_q.pop_front());
                        beats++;
                    end else begin
                        stalls++;
                    end
                end
            end
            if (done) begin
                chk("done_in_dump", 64'(starts > finishes), 64'd1);
                chk("done_busy", 64'(busy), 64'd1);
                chk("dump_cycles", 64'(cyc), 64'(int'(NREGS) + beats + stalls + 1));
                chk("beats_missing", 64'(exp_q.size()), 64'd0);
                chk("done_seq", 64'(out_seq), 64'(exp_seq));
                last_cycles    = cyc;
                last_beats     = beats;
                last_stalls    = stalls;
                last_first_idx = first_idx;
                last_seq       = out_seq;
                exp_seq        = exp_seq + 8'd1;
                finishes++;
                gap = 0;
            end
        end
    endtask

    task automatic drive_ready();
        if (ready_mode == 0) begin
            out_ready = 1'b1;
        end else if (ready_mode == 1) begin
            out_ready = ($urandom_range(0, 3) != 0);
        end else if (out_valid && beats == 5 && stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
        end else begin
            out_ready = 1'b1;
        end
    endtask

    task automatic do_dump();
        int n = 0;
        @(posedge clk); #1;
        while (busy && n < LIMIT) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_before_start", 64'(busy), 64'd0);
        stall_left = 3;
        start = 1'b1;
        starts++;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (finishes < starts && n < LIMIT) begin
            @(posedge clk); #1;
            n++;
        end
        chk("dump_completes", 64'(finishes >= starts), 64'd1);
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < int'(NREGS); i++) regs[i] = '0;
        #2 rst = 1'b0;

        fork
            forever begin @(negedge clk); compare_cycle(); end
            forever begin @(posedge clk); #1; drive_ready(); end
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_last", 64'(out_last), 64'd0);
        chk("rst_index", 64'(out_index), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_seq", 64'(out_seq), 64'd0);
        chk("rst_raddr", 64'(rf_raddr), 64'd0);
        @(posedge clk); #3 rst = 1'b1;

`ifndef REG_DUMP_CHANGED_ONLY_EN
        // Full dump with ready tied high, then with a 3-cycle stall on beat 5
        for (int i = 0; i < int'(NREGS); i++) regs[i] = WIDTH'(i * 32'h1111_1111);
        ready_mode = 0;
        do_dump(); wait_done();
        chk("d1_cycles", 64'(last_cycles), 64'd33);
        chk("d1_beats", 64'(last_beats), 64'd16);
        chk("d1_first", 64'(last_first_idx), 64'd0);
        chk("d1_seq", 64'(last_seq), 64'd0);
        ready_mode = 2;
        do_dump(); wait_done();
        chk("d2_cycles", 64'(last_cycles), 64'd36);
        chk("d2_stalls", 64'(last_stalls), 64'd3);
        chk("d2_beats", 64'(last_beats), 64'd16);
        chk("d2_seq", 64'(last_seq), 64'd1);
`else
        // Changed-only: one nonzero register, then one change, then none
        regs[3] = 32'hA;
        ready_mode = 0;
        do_dump(); wait_done();
        chk("c1_beats", 64'(last_beats), 64'd1);
        chk("c1_first", 64'(last_first_idx), 64'd3);
        chk("c1_cycles", 64'(last_cycles), 64'd18);
        regs[15] = 32'h5;
        do_dump(); wait_done();
        chk("c2_beats", 64'(last_beats), 64'd1);
        chk("c2_first", 64'(last_first_idx), 64'd15);
        do_dump(); wait_done();
        chk("c3_beats", 64'(last_beats), 64'd0);
        chk("c3_cycles", 64'(last_cycles), 64'd17);
        chk("c3_seq", 64'(last_seq), 64'd2);
`endif

        // start pulses while busy must be ignored
        for (int i = 0; i < int'(NREGS); i++) regs[i] = $urandom;
        ready_mode = 1;
        do_dump();
        repeat (3) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done();
        repeat (4) @(posedge clk);
        #1;
        chk("ignored_start_idle", 64'(busy), 64'd0);

        // start held high: back-to-back dumps with one idle cycle between
        ready_mode = 0;
        start = 1'b1;
        starts = starts + 2;
        n = 0;
        while (finishes < starts - 1 && n < LIMIT) begin @(posedge clk); #1; n++; end
        while (!busy && n < LIMIT) begin @(posedge clk); #1; n++; end
        start = 1'b0;
        chk("held_start_restarts", 64'(busy), 64'd1);
        wait_done();
        chk("held_start_gap", 64'(last_gap), 64'd1);

        // Randomized dumps, enough to wrap the sequence number
        for (int k = 0; k < 260; k++) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                if ($urandom_range(0, 3) == 0) regs[i] = $urandom;
            end
            ready_mode = $urandom_range(0, 2);
            do_dump(); wait_done();
        end

        // Reset during beat 7
        for (int i = 0; i < int'(NREGS); i++) regs[i] = ~shadow_m[i];
        ready_mode = 0;
        do_dump();
        n = 0;
        while (!(beats == 7 && out_valid) && n < LIMIT) begin @(posedge clk); #1; n++; end
        chk("beat7_reached", 64'(beats == 7 && out_valid), 64'd1);
        #2 rst = 1'b0;
        #1;
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("post_rst_idle", 64'(busy), 64'd0);
        do_dump(); wait_done();
        chk("post_rst_seq", 64'(last_seq), 64'd0);
        if (!CHG) chk("post_rst_first", 64'(last_first_idx), 64'd0);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/reg_dump_unit.md
# reg_dump_unit

Hardware register-file dump engine that walks every architectural register through a read port and streams `{index, value}` beats out over a valid/ready interface. It sits beside the CPU register file and replaces bench-side hierarchical peeking with a synthesizable, parametrised debug path usable on silicon and in simulation. An optional changed-only mode emits only registers whose value differs from the previous dump.

## Interface
Parameters:
- `NREGS`, 16: number of registers walked, ≥2
- `WIDTH`, 32: register width in bits
- `IDX_W`, $clog2(NREGS): index width

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  request a dump; sampled only in IDLE
- `busy`  out  1  high whenever state ≠ IDLE
- `done`  out  1  one-cycle pulse at end of dump
- `rf_raddr`  out  IDX_W  register file read address
- `rf_rdata`  in  WIDTH  combinational read data for `rf_raddr`, same cycle
- `out_valid`  out  1  beat valid
- `out_ready`  in  1  consumer ready
- `out_index`  out  IDX_W  register index of beat
- `out_data`  out  WIDTH  register value of beat
- `out_last`  out  1  beat carries index NREGS-1
- `out_seq`  out  8  dump sequence number

## Operation
- FSM states: IDLE, LOAD, SEND, DONE.
- IDLE: `start`=1 → idx←0, LOAD. `start` outside IDLE ignored (no queuing).
- LOAD: `rf_raddr`=idx; capture `rf_rdata`→`out_data`, idx→`out_index`, set `out_valid`, `out_last`=(idx==NREGS-1); → SEND.
- SEND: hold all out_* stable while `out_ready`=0. On handshake (valid&ready): clear `out_valid`; idx==NREGS-1 → DONE, else idx+1 → LOAD.
- DONE: `done`=1 one cycle; `out_seq`+1 (wraps 255→0); → IDLE.
- Values are sampled in each register's LOAD cycle; concurrent CPU writes are not snapshotted atomically.
- `out_seq` constant during a dump; first dump after reset carries 0.
- `rf_raddr` = idx in every state (0 in IDLE).

## Timing
- Reset (async assert, sync release): state IDLE, idx 0, `busy`/`done`/`out_valid`/`out_last` 0, `out_index`/`out_data` 0, `out_seq` 0, `rf_raddr` 0.
- Reset mid-dump: `out_valid` drops immediately, dump abandoned, no `done`.
- `start` high at edge E0 → `busy` high after E0; first `out_valid` after E1.
- `out_ready` tied high: one beat per 2 cycles; `done` in cycle after edge E(2·NREGS); `busy` high 2·NREGS+1 cycles (33 for NREGS=16).
- Each cycle of `out_ready`=0 in SEND adds exactly one cycle.
- `start` held high continuously: new dump begins the cycle after DONE (one IDLE cycle between dumps).

## Configuration
- `REG_DUMP_CHANGED_ONLY_EN` defined: per-register shadow copy (reset 0). In LOAD, if `rf_rdata` == shadow[idx], no beat: skip straight to next LOAD (or DONE after NREGS-1), 1 cycle per skipped register. Shadow[idx] updated on handshake. `out_last` asserted only if index NREGS-1 is emitted; zero-beat dumps still pulse `done` and bump `out_seq`. After reset, first dump emits only nonzero registers.
- Undefined: every register emitted every dump; no shadow storage.

## Structure
- Package `reg_dump_pkg`: FSM state enum, default `NREGS`/`WIDTH`, `SEQ_W`=8 constant.
- Sub-module `reg_dump_shadow` (NREGS×WIDTH store, compare + write port), instantiated only under `REG_DUMP_CHANGED_ONLY_EN`.

## Test plan
- Reset, regs r[i]=i·0x11111111, `out_ready`=1, pulse `start` → 16 beats index 0..15 with matching data, `out_last` only on 15, `done` 33 cycles after start edge, `out_seq`=0.
- Consumer stalls `out_ready`=0 for 3 cycles on beat 5 → out_index/out_data stable for the stall, total dump 36 cycles, no beat lost or duplicated.
- Pulse `start` while `busy` → ignored, single dump only; second dump afterward carries `out_seq`=1; 256 dumps wrap `out_seq` to 0.
- Assert `rst` low during beat 7 → `out_valid` and `busy` 0 immediately, no `done`; fresh `start` restarts at index 0.
- `REG_DUMP_CHANGED_ONLY_EN`: regs all 0 except r3=0xA → dump1 emits only index 3; modify r15=0x5 → dump2 emits only index 15 with `out_last`=1; no change → dump3 zero beats, `done` after 17 cycles.
